// File: rtl/ppb_io_sync.sv
// Board pin conditioning: synchronise, debounce and edge-detect every board input,
// and register the CPU observation vector onto the board outputs with a freeze/snapshot mode.
module ppb_io_sync #(
  parameter int unsigned N_IN            = 60,
  parameter int unsigned N_OUT           = 120,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  device_inputs,
  output logic [N_IN-1:0]  in_stable,
  output logic [N_IN-1:0]  in_rise,
  output logic [N_IN-1:0]  in_fall,
  input  logic [N_OUT-1:0] out_src,
  input  logic             freeze,
  output logic [N_OUT-1:0] device_outputs,
  output logic             out_changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_IN-1:0]  s1_q, s1_d;
  logic [N_IN-1:0]  s2_q, s2_d;
  logic [N_IN-1:0]  stable_q, stable_d;
  logic [N_IN-1:0]  prev_q, prev_d;
  logic [N_IN-1:0]  rise_q, rise_d;
  logic [N_IN-1:0]  fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];

  logic [N_OUT-1:0] dout_q, dout_d;
  logic             changed_q, changed_d;

  // Input path: synchroniser, per-bit debounce counter, and edge pulses one cycle after the flip
  always_comb begin
    s1_d     = device_inputs;
    s2_d     = s1_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    for (int unsigned i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    // prev_q lags stable_q by one cycle, so these fire in the cycle after stable_q flips
    rise_d = stable_q & ~prev_q;
    fall_d = ~stable_q & prev_q;
  end

  // Output path: mirror out_src unless frozen; flag value changes in the same cycle they appear
  always_comb begin
    dout_d    = dout_q;
    changed_d = 1'b0;
    if (!freeze) begin
      dout_d    = out_src;
      changed_d = (out_src != dout_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      dout_q    <= '0;
      changed_q <= 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      prev_q    <= prev_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      dout_q    <= dout_d;
      changed_q <= changed_d;
      for (int unsigned i = 0; i < N_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign in_stable      = stable_q;
  assign in_rise        = rise_q;
  assign in_fall        = fall_q;
  assign device_outputs = dout_q;
  assign out_changed    = changed_q;

endmodule

// File: tb/tb_ppb_io_sync.sv
// Bench for ppb_io_sync: a DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1 instance share stimulus
// and are checked every cycle against a window-based reference model plus directed checks.
module tb_ppb_io_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic [7:0] osrc;
  logic       frz;

  logic [3:0] st0, ri0, fa0, st1, ri1, fa1;
  logic [7:0] do0, do1;
  logic       ch0, ch1;

  always #5 clk = ~clk;

  ppb_io_sync #(.N_IN(4), .N_OUT(8), .DEBOUNCE_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .device_inputs(din),
    .in_stable(st0), .in_rise(ri0), .in_fall(fa0),
    .out_src(osrc), .freeze(frz), .device_outputs(do0), .out_changed(ch0)
  );

  ppb_io_sync #(.N_IN(4), .N_OUT(8), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .device_inputs(din),
    .in_stable(st1), .in_rise(ri1), .in_fall(fa1),
    .out_src(osrc), .freeze(frz), .device_outputs(do1), .out_changed(ch1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a level is accepted once the last D synchronised samples all disagree with it
  logic [3:0] m_s1, m_s2;
  logic [3:0] m_st [2];
  logic [3:0] m_pr [2];
  logic [3:0] m_pf [2];
  logic [3:0] m_ri [2];
  logic [3:0] m_fa [2];
  logic [3:0] hist [2][4];
  int         hcnt [2];
  int         dd   [2];
  logic [7:0] m_dev;
  logic       m_chg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_dev = '0; m_chg = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = '0; m_pr[k] = '0; m_pf[k] = '0; m_ri[k] = '0; m_fa[k] = '0;
      hcnt[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [3:0] nst;
    logic       all_diff;
    for (int k = 0; k < 2; k++) begin
      if (hcnt[k] < dd[k]) begin
        hist[k][hcnt[k]] = m_s2;
        hcnt[k]++;
      end else begin
        for (int j = 0; j < dd[k] - 1; j++) hist[k][j] = hist[k][j+1];
        hist[k][dd[k]-1] = m_s2;
      end
      m_ri[k] = m_pr[k];
      m_fa[k] = m_pf[k];
      nst = m_st[k];
      if (hcnt[k] == dd[k]) begin
        for (int b = 0; b < 4; b++) begin
          all_diff = 1'b1;
          for (int j = 0; j < dd[k]; j++)
            if (hist[k][j][b] == m_st[k][b]) all_diff = 1'b0;
          if (all_diff) nst[b] = ~m_st[k][b];
        end
      end
      m_pr[k] = nst & ~m_st[k];
      m_pf[k] = ~nst & m_st[k];
      m_st[k] = nst;
    end
    m_s2 = m_s1;
    m_s1 = din;
    m_chg = !frz && (osrc != m_dev);
    if (!frz) m_dev = osrc;
  endtask

  task automatic compare_all();
    chk("stable_d4", 32'(st0), 32'(m_st[0]));
    chk("rise_d4",   32'(ri0), 32'(m_ri[0]));
    chk("fall_d4",   32'(fa0), 32'(m_fa[0]));
    chk("stable_d1", 32'(st1), 32'(m_st[1]));
    chk("rise_d1",   32'(ri1), 32'(m_ri[1]));
    chk("fall_d1",   32'(fa1), 32'(m_fa[1]));
    chk("dout_d4",   32'(do0), 32'(m_dev));
    chk("dout_d1",   32'(do1), 32'(m_dev));
    chk("chg_d4",    32'(ch0), 32'(m_chg));
    chk("chg_d1",    32'(ch1), 32'(m_chg));
  endtask

  // One clock: model advances at the edge, DUT is sampled at the following falling edge
  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int n;
    int cnt_a, cnt_b, cnt_c;
    dd[0] = 4; dd[1] = 1;
    reset = 1'b1; din = '0; osrc = '0; frz = 1'b0;
    model_reset();
    cyc(); cyc();
    chk("reset_stable", 32'(st0), 32'h0);
    chk("reset_dout",   32'(do0), 32'h0);
    reset = 1'b0;
    repeat (3) cyc();

    // Clean rising edge on bit1
    din[1] = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(); n++;
      if (st0[1]) break;
    end
    chk("clean_latency_edges", 32'(n), 32'd6);
    chk("clean_rise_before", 32'(ri0[1]), 32'd0);
    cyc();
    chk("clean_rise_pulse", 32'(ri0[1]), 32'd1);
    chk("clean_others", 32'(st0 & 4'b1101), 32'h0);
    cyc();
    chk("clean_rise_end", 32'(ri0[1]), 32'd0);

    // Bounce on bit0: 3-cycle highs are rejected, the final hold is accepted once
    cnt_a = 0;
    for (int p = 0; p < 4; p++) begin
      din[0] = (p % 2 == 0);
      repeat (3) begin cyc(); cnt_a += int'(ri0[0]); end
    end
    repeat (3) begin cyc(); cnt_a += int'(ri0[0]); end
    chk("bounce_no_rise", 32'(cnt_a), 32'd0);
    din[0] = 1'b1;
    cnt_b = 0;
    repeat (12) begin cyc(); cnt_b += int'(ri0[0]); end
    chk("bounce_one_rise", 32'(cnt_b), 32'd1);

    // Falling edge on bit2 interrupted by asynchronous reset
    din[2] = 1'b1;
    repeat (10) cyc();
    chk("bit2_high", 32'(st0[2]), 32'd1);
    din[2] = 1'b0;
    cyc(); cyc();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_stable", 32'({st0, st1}), 32'h0);
    chk("async_rst_pulses", 32'({ri0, fa0, ri1, fa1}), 32'h0);
    chk("async_rst_dout",   32'({do0, do1, 7'd0, ch0}), 32'h0);
    @(negedge clk);
    cyc();
    reset = 1'b0;
    cnt_a = 0; cnt_b = 0;
    repeat (10) begin cyc(); cnt_a += int'(fa0[2]); cnt_b += int'(ri0[2]); end
    chk("post_rst_no_fall2", 32'(cnt_a), 32'd0);
    chk("post_rst_no_rise2", 32'(cnt_b), 32'd0);
    chk("post_rst_stable2",  32'(st0[2]), 32'd0);
    chk("held_high_rerises", 32'(st0[1:0]), 32'h3);

    // Output mirroring
    osrc = 8'h00; cyc();
    osrc = 8'hA5; cyc();
    chk("mirror_dout", 32'(do0), 32'hA5);
    chk("mirror_chg",  32'(ch0), 32'd1);
    cyc();
    chk("mirror_chg_off", 32'(ch0), 32'd0);

    // Freeze holds the snapshot
    frz = 1'b1; osrc = 8'h3C;
    cnt_a = 0; cnt_b = 0;
    repeat (10) begin
      cyc();
      cnt_a += int'(do0 != 8'hA5);
      cnt_b += int'(ch0);
    end
    chk("freeze_hold", 32'(cnt_a), 32'd0);
    chk("freeze_chg",  32'(cnt_b), 32'd0);
    frz = 1'b0;
    cyc();
    chk("unfreeze_dout", 32'(do0), 32'h3C);
    chk("unfreeze_chg",  32'(ch0), 32'd1);

    // Degenerate filter: one-cycle raw pulse on bit3 through the DEBOUNCE_CYCLES=1 instance
    din[3] = 1'b1; cyc();
    din[3] = 1'b0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    repeat (8) begin
      cyc();
      cnt_a += int'(st1[3]); cnt_b += int'(ri1[3]); cnt_c += int'(fa1[3]);
    end
    chk("d1_stable_cycles", 32'(cnt_a), 32'd1);
    chk("d1_rise_count",    32'(cnt_b), 32'd1);
    chk("d1_fall_count",    32'(cnt_c), 32'd1);
    chk("d4_filters_pulse", 32'(st0[3]), 32'd0);

    // Randomised traffic checked against the model every cycle
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) din[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 1) == 0) osrc = 8'($urandom);
      frz = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
